dpram_stream_reader: RTL and testbench
======================================

// Module: dpram_stream_reader
// PURPOSE
//  Read-side engine for one port of dpram. On a start command it reads a
//  contiguous address range from the RAM and streams the words out over a
//  valid/ready interface. It absorbs the RAM's 1-cycle registered read latency
//  and output back-pressure with an internal 4-entry buffer.
//  Used by boot/loader logic to drain buffers that another agent fills.
// PARAMETERS
//  DATAWIDTH  8  RAM word width, also the stream width
//  ADDRWIDTH  8  RAM address width; addresses wrap modulo 2**ADDRWIDTH
// PORTS
//  clock        in   1            single system clock, rising edge
//  reset        in   1            synchronous, active-high
//  start        in   1            1-cycle command strobe; ignored while busy=1
//  base_addr    in   ADDRWIDTH    first address, sampled with start
//  length       in   ADDRWIDTH+1  word count 0..2**ADDRWIDTH, sampled with start
//  abort        in   1            cancel the transfer in progress; ignored when idle
//  mem_address  out  ADDRWIDTH    drives dpram address_x
//  mem_wren     out  1            drives dpram wren_x; constant 0
//  mem_q        in   DATAWIDTH    from dpram q_x; valid 1 cycle after the address
//  out_data     out  DATAWIDTH    stream data, taken from the buffer head
//  out_valid    out  1            stream valid
//  out_ready    in   1            stream ready; a word transfers when valid&ready
//  busy         out  1            1 from the cycle after start until done or abort
//  done         out  1            1-cycle pulse after the last word transfers
// BEHAVIOUR
//  - Reset: state=IDLE, buffer empty, outstanding=0.
//    out_valid=0, busy=0, done=0, mem_address=0, out_data=0, mem_wren=0.
//  - States: IDLE -> RUN on start with length!=0.
//    IDLE -> FINISH on start with length==0.
//    RUN -> DRAIN when the last read has issued.
//    DRAIN -> FINISH when the buffer is empty, no read is outstanding,
//    and the last word has transferred.
//    FINISH -> IDLE after 1 cycle with done=1.
//    RUN/DRAIN -> IDLE on abort; done stays 0.
//  - Read issue: in RUN, a read issues in a cycle when
//    occupancy + outstanding < 4 (a same-cycle pop is not counted).
//    The issued address is the registered mem_address.
//    After each issue, mem_address increments with wrap-around and remaining decrements.
//  - The buffer captures mem_q in the cycle after each issue.
//    With out_ready held at 1 the stream runs at 1 word per clock.
//  - Latency: start sampled at edge E. mem_address=base_addr from E+1.
//    First out_valid at E+3.
//  - Stream handshake: out_data and out_valid only change after a transfer.
//    Once out_valid=1, out_data stays stable until valid&ready.
//    Words are delivered in ascending address order.
//    Neither duplicates nor drops are allowed; overflow is impossible by the credit rule.
//  - Push and pop in the same cycle are both legal, and occupancy stays unchanged.
//  - Abort: clears the buffer, drops an outstanding read, and sets out_valid=0 at the next edge.
//  - reset overrides every input, including a start or abort in the same cycle.
//  - length = 2**ADDRWIDTH reads the full RAM once, starting at base_addr.
// TESTING
//  1. Reset held 2 cycles -> every output is 0, including mem_wren.
//  2. Preload mem[i]=i^8'hA5. start, base=8'h10, len=4, ready=1 ->
//     A5^10..A5^13 on 4 consecutive cycles starting at E+3, then done=1 for 1 cycle, busy=0.
//  3. base=8'hFE, len=4, ready toggling 1,0,0,1,... ->
//     addresses FE,FF,00,01. Data is stable while ready=0 and correct in order.
//     At no point does occupancy exceed 4.
//  4. len=0 -> no out_valid, busy high 1 cycle, done pulse at E+2.
//  5. len=256, ready low for 20 cycles and then high ->
//     all 256 words are delivered once, in order, with one done pulse.
//     A start pulse issued mid-transfer is ignored.
//  6. abort after 3 of 10 words, then start base=0 len=2 ->
//     no done for the first transfer, buffer flushed, and only mem[0],mem[1] are delivered afterwards.

Source files
------------

// File: rtl/dpram_stream_reader.sv
// dpram_stream_reader: streams a contiguous dpram address range out over valid/ready through a 4-entry credit-managed buffer
module dpram_stream_reader #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDRWIDTH-1:0] base_addr,
  input  logic [ADDRWIDTH:0]   length,
  input  logic                 abort,
  output logic [ADDRWIDTH-1:0] mem_address,
  output logic                 mem_wren,
  input  logic [DATAWIDTH-1:0] mem_q,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;
  state_t state, state_nx;
  logic [ADDRWIDTH:0] remaining;
  logic [DATAWIDTH-1:0] fifo [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic outstanding, issue, push, pop, kill;
  always_comb begin
    kill = abort && (state == RUN || state == DRAIN);
    issue = state == RUN && !kill && (count + 3'(outstanding)) < 3'd4;
    push = outstanding && !kill;
    pop = out_valid && out_ready;
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? (length == '0 ? FINISH : RUN) : IDLE;
      RUN:     state_nx = issue && remaining == (ADDRWIDTH+1)'(1) ? DRAIN : RUN;
      DRAIN:   state_nx = count == '0 && !outstanding ? FINISH : DRAIN;
      default: state_nx = IDLE;
    endcase
    state_nx = kill ? IDLE : state_nx;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      remaining <= '0;
      mem_address <= '0;
      outstanding <= 1'b0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      done <= state == FINISH;
      outstanding <= issue;
      if (state == IDLE && start) begin
        mem_address <= base_addr;
        remaining <= length;
      end else if (issue) begin
        mem_address <= mem_address + ADDRWIDTH'(1);
        remaining <= remaining - (ADDRWIDTH+1)'(1);
      end
      if (kill) begin
        count <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        count <= count + 3'(push) - 3'(pop);
        wr_ptr <= wr_ptr + 2'(push);
        rd_ptr <= rd_ptr + 2'(pop);
      end
    end
  end
  always_ff @(posedge clock) if (push) fifo[wr_ptr] <= mem_q;
  assign mem_wren = 1'b0;
  assign busy = state != IDLE;
  assign out_valid = count != '0;
  assign out_data = out_valid ? fifo[rd_ptr] : '0;
endmodule

// File: tb/tb_dpram_stream_reader.sv
// tb_dpram_stream_reader: scoreboard bench for dpram_stream_reader with a behavioural RAM and stream model
module tb_dpram_stream_reader;
  logic clock = 0, reset = 1, start = 0, abort = 0, out_ready = 0;
  logic [7:0] base_addr = 0, mem_address, mem_q, out_data;
  logic [8:0] length = 0;
  logic mem_wren, out_valid, busy, done;
  logic [7:0] mem [256];
  logic [7:0] exp_q [$];
  int n_chk = 0, n_fail = 0, xfers = 0, done_cnt = 0, exp_done = 0, mode = 0, cyc = 0;
  logic pv = 0, pr = 0, pa = 0;
  logic [7:0] pd = 0;

  dpram_stream_reader #(.DATAWIDTH(8), .ADDRWIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .abort(abort), .mem_address(mem_address), .mem_wren(mem_wren), .mem_q(mem_q),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done));

  always #5 clock = ~clock;
  always @(posedge clock) mem_q <= mem[mem_address];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) if (!reset) begin
    chk("mem_wren", 32'(mem_wren), 0);
    if (pv && !pr && !pa) chk("hold_stable", {23'd0, out_valid, out_data}, {23'd0, 1'b1, pd});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
      else chk("stream_data", 32'(out_data), 32'(exp_q.pop_front()));
      xfers++;
    end
    if (done) done_cnt++;
    pv = out_valid; pr = out_ready; pa = abort; pd = out_data;
  end

  task automatic step();
    @(posedge clock); #1;
    cyc++;
    start = 0;
    abort = 0;
    out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'(cyc % 3 == 0) : mode == 2 ? 1'($urandom % 2) : 1'b0;
  endtask

  task automatic do_start(logic [7:0] b, logic [8:0] l);
    for (int i = 0; i < int'(l); i++) begin
      logic [7:0] a;
      a = b + 8'(i);
      exp_q.push_back(mem[a]);
    end
    exp_done++;
    base_addr = b;
    length = l;
    start = 1;
    step();
  endtask

  task automatic wait_done(int bound);
    int n = 0;
    while (!done && n < bound) begin step(); n++; end
    chk("done_seen", 32'(done), 1);
    chk("drained_at_done", {31'(exp_q.size()), busy}, 0);
    step();
    chk("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    reset = 1; start = 1; abort = 1; base_addr = 8'h55; length = 9'd5;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outputs", {mem_address, out_data, 4'(out_valid), 4'(busy), 4'(done), 4'(mem_wren)}, 0);
    reset = 0; start = 0; abort = 0;
    step();
    chk("reset_overrides_start", {mem_address, 7'd0, busy}, 0);
    mode = 0;
    step();
    do_start(8'h10, 9'd4);
    chk("addr_at_e1", {mem_address, 7'd0, out_valid}, {8'h10, 8'h00});
    step();
    chk("no_valid_e2", 32'(out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("burst_word", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h10 + 8'(i) ^ 8'hA5});
    end
    wait_done(50);
    mode = 1;
    do_start(8'hFE, 9'd4);
    chk("wrap_base_addr", 32'(mem_address), 32'hFE);
    wait_done(200);
    mode = 0;
    step();
    do_start(8'h20, 9'd0);
    chk("len0_e1", {busy, done, out_valid}, 3'b100);
    step();
    chk("len0_done_e2", {busy, done, out_valid}, 3'b010);
    step();
    chk("len0_after", {busy, done, out_valid}, 3'b000);
    mode = 3;
    x0 = xfers;
    do_start(8'h80, 9'd256);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin base_addr = 8'h77; length = 9'd3; start = 1; end
      step();
    end
    chk("held_no_xfer", 32'(xfers - x0), 0);
    mode = 0;
    wait_done(600);
    chk("full_ram_count", 32'(xfers - x0), 256);
    x0 = xfers;
    do_start(8'h40, 9'd10);
    for (int n = 0; n < 100 && xfers - x0 < 3; n++) step();
    mode = 3;
    out_ready = 0;
    abort = 1;
    exp_q.delete();
    exp_done--;
    step();
    chk("abort_idle", {out_valid, busy}, 0);
    chk("abort_after_three", 32'(xfers - x0), 3);
    repeat (4) step();
    chk("abort_no_done", 32'(done_cnt), 32'(exp_done));
    mode = 0;
    x0 = xfers;
    do_start(8'h00, 9'd2);
    wait_done(50);
    chk("post_abort_count", 32'(xfers - x0), 2);
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mode = 2;
    for (int t = 0; t < 8; t++) begin
      do_start(8'($urandom), 9'($urandom_range(0, 40)));
      wait_done(2000);
      repeat (int'($urandom_range(0, 3))) step();
    end
    repeat (3) step();
    chk("done_pulse_total", 32'(done_cnt), 32'(exp_done));
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
